// File: rtl/core_pkg.sv
// Shared definitions for the core counter/timer unit: counter width,
// counter CSR select codes and mcountinhibit bit positions.
package core_pkg;

   localparam int CTR_W = 64;

   typedef enum logic [2:0] {
      CSR_SEL_MCYCLE        = 3'd0,
      CSR_SEL_MINSTRET      = 3'd1,
      CSR_SEL_MTIME         = 3'd2,
      CSR_SEL_MTIMECMP      = 3'd3,
      CSR_SEL_MCOUNTINHIBIT = 3'd4
   } csr_sel_e;

   localparam int MCI_CY = 0;
   localparam int MCI_TM = 1;
   localparam int MCI_IR = 2;

endpackage

// File: rtl/core_counter64.sv
// Loadable modulo counter; a load takes priority over an increment in the
// same cycle, so the written value is not also bumped.
module core_counter64 #(
   parameter int W = 64
) (
   input  logic         g_clk,
   input  logic         g_reset,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] value
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         value <= '0;
      end else if (load) begin
         value <= wdata;
      end else if (inc) begin
         value <= value + W'(1);
      end
   end

endmodule

// File: rtl/core_counters.sv
// Architectural counter/timer unit: mcycle, mtime, minstret, mtimecmp,
// mcountinhibit and the machine timer interrupt.
module core_counters #(
   parameter int unsigned TIME_DIV = 1,
   parameter int          CTR_W    = core_pkg::CTR_W
) (
   input  logic             g_clk,
   input  logic             g_reset,
   input  logic             instr_ret,
   input  logic             csr_wen,
   input  logic [2:0]       csr_wsel,
   input  logic [CTR_W-1:0] csr_wdata,
   output logic [CTR_W-1:0] ctr_cycle,
   output logic [CTR_W-1:0] ctr_time,
   output logic [CTR_W-1:0] ctr_instret,
   output logic [CTR_W-1:0] ctr_timecmp,
   output logic             inhibit_cy,
   output logic             inhibit_tm,
   output logic             inhibit_ir,
   output logic             int_ti
);

   import core_pkg::*;

   localparam logic [CTR_W-1:0] PRESC_LAST = CTR_W'(TIME_DIV - 1);

   logic [CTR_W-1:0] presc;
   logic [2:0]       inhibit_q;
   logic             time_tick;
   logic             ld_cycle, ld_instret, ld_time, ld_timecmp, ld_inhibit;

   // Decode the write strobe; selects 5..7 fall through and change nothing.
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      ld_cycle   = 1'b0;
      ld_instret = 1'b0;
      ld_time    = 1'b0;
      ld_timecmp = 1'b0;
      ld_inhibit = 1'b0;
      if (csr_wen) begin
         case (csr_wsel)
            CSR_SEL_MCYCLE:        ld_cycle   = 1'b1;
            CSR_SEL_MINSTRET:      ld_instret = 1'b1;
            CSR_SEL_MTIME:         ld_time    = 1'b1;
            CSR_SEL_MTIMECMP:      ld_timecmp = 1'b1;
            CSR_SEL_MCOUNTINHIBIT: ld_inhibit = 1'b1;
            default: ;
         endcase
      end
   end

   // mtime advances on the cycle the prescaler wraps; both freeze while inhibited.
   assign time_tick = !inhibit_q[MCI_TM] && (presc == PRESC_LAST);

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         presc <= '0;
      end else if (ld_time) begin
         presc <= '0;
      end else if (!inhibit_q[MCI_TM]) begin
         presc <= time_tick ? '0 : presc + CTR_W'(1);
      end
   end

   // Inhibit bits written this cycle only affect counting from the next cycle.
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         inhibit_q   <= '0;
         ctr_timecmp <= '1;
         int_ti      <= 1'b0;
      end else begin
         if (ld_inhibit) inhibit_q <= csr_wdata[2:0];
         if (ld_timecmp) ctr_timecmp <= csr_wdata;
         int_ti <= (ctr_time >= ctr_timecmp);
      end
   end

   assign inhibit_cy = inhibit_q[MCI_CY];
   assign inhibit_tm = inhibit_q[MCI_TM];
   assign inhibit_ir = inhibit_q[MCI_IR];

   core_counter64 #(.W(CTR_W)) u_mcycle (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .inc     (!inhibit_q[MCI_CY]),
      .load    (ld_cycle),
      .wdata   (csr_wdata),
      .value   (ctr_cycle)
   );

   core_counter64 #(.W(CTR_W)) u_mtime (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .inc     (time_tick),
      .load    (ld_time),
      .wdata   (csr_wdata),
      .value   (ctr_time)
   );

   core_counter64 #(.W(CTR_W)) u_minstret (
      .g_clk   (g_clk),
      .g_reset (g_reset),
      .inc     (instr_ret && !inhibit_q[MCI_IR]),
      .load    (ld_instret),
      .wdata   (csr_wdata),
      .value   (ctr_instret)
   );

endmodule

// File: tb/tb_core_counters.sv
// Scoreboarded bench for core_counters: one instance at TIME_DIV=1, one at
// TIME_DIV=4, each tracked by a cycle model plus directed constant checks.
module tb_core_counters;

   logic        g_clk = 1'b0;
   logic        g_reset;

   logic        ret_a, wen_a, ret_b, wen_b;
   logic [2:0]  sel_a, sel_b;
   logic [63:0] wd_a, wd_b;
   logic [63:0] cyc_a, tim_a, ins_a, cmp_a, cyc_b, tim_b, ins_b, cmp_b;
   logic        icy_a, itm_a, iir_a, ti_a, icy_b, itm_b, iir_b, ti_b;

   always #5 g_clk = ~g_clk;

   core_counters #(.TIME_DIV(1)) u_dut_a (
      .g_clk(g_clk), .g_reset(g_reset), .instr_ret(ret_a), .csr_wen(wen_a),
      .csr_wsel(sel_a), .csr_wdata(wd_a), .ctr_cycle(cyc_a), .ctr_time(tim_a),
      .ctr_instret(ins_a), .ctr_timecmp(cmp_a), .inhibit_cy(icy_a),
      .inhibit_tm(itm_a), .inhibit_ir(iir_a), .int_ti(ti_a)
   );

   core_counters #(.TIME_DIV(4)) u_dut_b (
      .g_clk(g_clk), .g_reset(g_reset), .instr_ret(ret_b), .csr_wen(wen_b),
      .csr_wsel(sel_b), .csr_wdata(wd_b), .ctr_cycle(cyc_b), .ctr_time(tim_b),
      .ctr_instret(ins_b), .ctr_timecmp(cmp_b), .inhibit_cy(icy_b),
      .inhibit_tm(itm_b), .inhibit_ir(iir_b), .int_ti(ti_b)
   );

   typedef struct {
      logic [63:0] cycle, mtime, instret, timecmp, presc;
      logic [2:0]  inh;
      logic        ti;
   } mdl_t;

   typedef struct {
      mdl_t a;
      mdl_t b;
   } exp_t;

   exp_t exp_q[$];
   mdl_t ma, mb;
   bit   use_b;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.cycle = '0; r.mtime = '0; r.instret = '0; r.presc = '0;
      r.timecmp = '1; r.inh = '0; r.ti = 1'b0;
      return r;
   endfunction

   // Architectural next state from the current state and this cycle's inputs.
   function automatic mdl_t mdl_next(input mdl_t s, input int unsigned div, input logic ret,
                                     input logic wen, input logic [2:0] sel, input logic [63:0] wd);
      mdl_t n = s;
      logic tick;
      n.ti = (s.mtime >= s.timecmp);
      if (!s.inh[0]) n.cycle = s.cycle + 64'd1;
      if (ret && !s.inh[2]) n.instret = s.instret + 64'd1;
      tick = !s.inh[1] && (s.presc == 64'(div - 1));
      if (!s.inh[1]) n.presc = tick ? 64'd0 : s.presc + 64'd1;
      if (tick) n.mtime = s.mtime + 64'd1;
      if (wen) begin
         case (sel)
            3'd0: n.cycle = wd;
            3'd1: n.instret = wd;
            3'd2: begin n.mtime = wd; n.presc = '0; end
            3'd3: n.timecmp = wd;
            3'd4: n.inh = wd[2:0];
            default: ;
         endcase
      end
      return n;
   endfunction

   task automatic cmp_out(input string p, input mdl_t e, input logic [63:0] c, input logic [63:0] t,
                          input logic [63:0] i, input logic [63:0] m, input logic [2:0] inh,
                          input logic ti);
      check({p, "_cycle"}, c, e.cycle);
      check({p, "_time"}, t, e.mtime);
      check({p, "_instret"}, i, e.instret);
      check({p, "_timecmp"}, m, e.timecmp);
      check({p, "_inhibit"}, 64'(inh), 64'(e.inh));
      check({p, "_int_ti"}, 64'(ti), 64'(e.ti));
   endtask

   task automatic drive_idle();
      ret_a = 0; wen_a = 0; sel_a = '0; wd_a = '0;
      ret_b = 0; wen_b = 0; sel_b = '0; wd_b = '0;
   endtask

   // One clock: drive the active instance, push the model's prediction,
   // then pop and compare after the edge.
   task automatic tick(input logic ret, input logic wen, input logic [2:0] sel, input logic [63:0] wd);
      exp_t e;
      drive_idle();
      if (use_b) begin ret_b = ret; wen_b = wen; sel_b = sel; wd_b = wd; end
      else       begin ret_a = ret; wen_a = wen; sel_a = sel; wd_a = wd; end
      ma = mdl_next(ma, 1, ret_a, wen_a, sel_a, wd_a);
      mb = mdl_next(mb, 4, ret_b, wen_b, sel_b, wd_b);
      e.a = ma;
      e.b = mb;
      exp_q.push_back(e);
      @(posedge g_clk);
      #1;
      e = exp_q.pop_front();
      cmp_out("a", e.a, cyc_a, tim_a, ins_a, cmp_a, {iir_a, itm_a, icy_a}, ti_a);
      cmp_out("b", e.b, cyc_b, tim_b, ins_b, cmp_b, {iir_b, itm_b, icy_b}, ti_b);
   endtask

   task automatic do_reset();
      g_reset = 1'b1;
      drive_idle();
      @(posedge g_clk);
      #1;
      ma = mdl_reset();
      mb = mdl_reset();
      exp_q.delete();
      check("rst_a_cycle", cyc_a, 64'd0);
      check("rst_a_timecmp", cmp_a, 64'hFFFF_FFFF_FFFF_FFFF);
      check("rst_b_time", tim_b, 64'd0);
      cmp_out("rst_a", ma, cyc_a, tim_a, ins_a, cmp_a, {iir_a, itm_a, icy_a}, ti_a);
      cmp_out("rst_b", mb, cyc_b, tim_b, ins_b, cmp_b, {iir_b, itm_b, icy_b}, ti_b);
      g_reset = 1'b0;
   endtask

   initial begin
      int rise;
      use_b = 1'b0;
      do_reset();

      // Idle counting with TIME_DIV=1.
      repeat (10) tick(0, 0, 3'd0, 64'd0);
      check("idle_cycle", cyc_a, 64'd10);
      check("idle_time", tim_a, 64'd10);
      check("idle_instret", ins_a, 64'd0);
      check("idle_int_ti", 64'(ti_a), 64'd0);

      // mcycle wrap.
      tick(0, 1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE);
      check("wrap_load", cyc_a, 64'hFFFF_FFFF_FFFF_FFFE);
      tick(0, 0, 3'd0, 64'd0);
      check("wrap_max", cyc_a, 64'hFFFF_FFFF_FFFF_FFFF);
      tick(0, 0, 3'd0, 64'd0);
      check("wrap_zero", cyc_a, 64'd0);

      // Inhibit CY and IR; the writing cycle still counts.
      tick(0, 1, 3'd4, 64'd5);
      check("inh_write_cycle", cyc_a, 64'd1);
      repeat (4) tick(1, 0, 3'd0, 64'd0);
      check("inh_cycle_frozen", cyc_a, 64'd1);
      check("inh_instret_frozen", ins_a, 64'd0);
      check("inh_time_runs", tim_a, 64'd18);
      tick(0, 1, 3'd4, 64'd0);
      check("uninh_cycle", cyc_a, 64'd1);

      // Write beats increment on minstret.
      tick(1, 1, 3'd1, 64'd100);
      check("ret_load", ins_a, 64'd100);
      tick(1, 0, 3'd0, 64'd0);
      check("ret_resume", ins_a, 64'd101);

      // Unused selects leave state alone.
      tick(0, 1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF);
      tick(0, 1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF);
      check("sel7_timecmp", cmp_a, 64'hFFFF_FFFF_FFFF_FFFF);
      check("sel7_inhibit", 64'({iir_a, itm_a, icy_a}), 64'd0);

      // Full-width compare across the 32-bit boundary.
      tick(0, 1, 3'd3, 64'h1_0000_0000);
      tick(0, 1, 3'd2, 64'h0_FFFF_FFFF);
      check("fw_time_load", tim_a, 64'h0_FFFF_FFFF);
      tick(0, 0, 3'd0, 64'd0);
      check("fw_below", 64'(ti_a), 64'd0);
      tick(0, 0, 3'd0, 64'd0);
      check("fw_equal", 64'(ti_a), 64'd1);

      // TIME_DIV=4 timer interrupt.
      do_reset();
      use_b = 1'b1;
      rise = 0;
      for (int n = 1; n <= 30 && rise == 0; n++) begin
         if (n == 1) tick(0, 1, 3'd3, 64'd3);
         else        tick(0, 0, 3'd0, 64'd0);
         if (ti_b) rise = n;
      end
      check("b_rise_edge", 64'(rise), 64'd13);
      check("b_time_at_rise", tim_b, 64'd3);
      tick(0, 1, 3'd3, 64'd50);
      check("b_cmp50_visible", cmp_b, 64'd50);
      check("b_ti_still_set", 64'(ti_b), 64'd1);
      tick(0, 0, 3'd0, 64'd0);
      check("b_ti_cleared", 64'(ti_b), 64'd0);
      tick(0, 1, 3'd2, 64'd100);
      repeat (5) tick(0, 0, 3'd0, 64'd0);
      check("b_time_after_load", tim_b, 64'd101);

      // Asynchronous reset mid-count.
      use_b = 1'b0;
      do_reset();
      repeat (37) tick(0, 0, 3'd0, 64'd0);
      check("pre_async_cycle", cyc_a, 64'd37);
      #2;
      g_reset = 1'b1;
      #1;
      check("async_cycle", cyc_a, 64'd0);
      check("async_time", tim_a, 64'd0);
      check("async_instret", ins_a, 64'd0);
      check("async_timecmp", cmp_a, 64'hFFFF_FFFF_FFFF_FFFF);
      check("async_inhibit", 64'({iir_a, itm_a, icy_a}), 64'd0);
      check("async_int_ti", 64'(ti_a), 64'd0);
      do_reset();
      tick(0, 0, 3'd0, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
